// File: rtl/rtc_offset_slew_ctrl.sv
// RTC offset controller: coarse direct time load for large offsets,
// bounded per-cycle period slew through the precise-adjust handshake.
module rtc_offset_slew_ctrl #(
  parameter int unsigned MAX_STEP_NS      = 4,
  parameter int unsigned COARSE_THRESH_NS = 1000000,
  parameter logic [31:0] STEP_DELAY       = 32'd0,
  parameter logic [37:0] LD_COMP          = 38'h1000,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_offset_ns,
  input  logic [37:0] time_reg_ns,
  input  logic [47:0] time_reg_sec,
  output logic        time_ld,
  output logic [37:0] time_reg_ns_out,
  output logic [47:0] time_reg_sec_out,
  output logic        adj_ld,
  output logic [31:0] adj_ld_data,
  output logic [39:0] period_adj,
  input  logic        adj_ld_done,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [30:0] remaining_ns
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLASSIFY,
    S_COARSE,
    S_TLD,
    S_FINE_LOAD,
    S_FINE_WAIT_LOW,
    S_FINE_WAIT_HIGH,
    S_DONE,
    S_ERR
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT_CYCLES - 1);
  localparam logic signed [39:0] SEC_NS8 =
    40'sd256000000000;
  localparam logic [31:0] MAX_LEGAL = 32'd999999999;
  localparam logic [30:0] STEP_MAX = 31'(MAX_STEP_NS);

  state_t state_q, state_d;

  logic [31:0]   off_q;
  logic [CW-1:0] cnt_q;
  logic [30:0]   rem_q;
  logic [39:0]   period_q;
  logic          adj_ld_q;
  logic [31:0]   adj_data_q;
  logic          tld_q;
  logic [37:0]   tns_q;
  logic [47:0]   tsec_q;

  logic [31:0]          mag;
  logic                 illegal;
  logic                 is_zero;
  logic                 is_coarse;
  logic                 timeout;
  logic [30:0]          step;
  logic [39:0]          mag_adj;
  logic [39:0]          adj_val;
  logic signed [39:0]   t_sum;
  logic [37:0]          ns_d;
  logic [47:0]          sec_d;

  // Offset classification and per-step correction value
  always_comb begin
    mag       = off_q[31] ? (~off_q + 32'd1) : off_q;
    illegal   = (off_q == 32'h8000_0000) ||
                (mag > MAX_LEGAL);
    is_zero   = (off_q == 32'd0);
    is_coarse = (mag >= 32'(COARSE_THRESH_NS));
    timeout   = (cnt_q == TO_LAST);
    step      = (rem_q < STEP_MAX) ? rem_q : STEP_MAX;
    mag_adj   = 40'(step) << 32;
    adj_val   = off_q[31] ? (~mag_adj + 40'd1) : mag_adj;
  end

  // Coarse load value, normalised into one second
  always_comb begin
    t_sum = $signed({2'b00, time_reg_ns}) +
            $signed({{8{off_q[31]}}, off_q, 8'h00}) +
            $signed({2'b00, LD_COMP});
    ns_d  = 38'(t_sum);
    sec_d = time_reg_sec;
    if (t_sum >= SEC_NS8) begin
      ns_d  = 38'(t_sum - SEC_NS8);
      sec_d = time_reg_sec + 48'd1;
    end else if (t_sum < 40'sd0) begin
      ns_d  = 38'(t_sum + SEC_NS8);
      sec_d = time_reg_sec - 48'd1;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (req_valid) state_d = S_CLASSIFY;
      S_CLASSIFY:
        if (illegal)        state_d = S_ERR;
        else if (is_zero)   state_d = S_DONE;
        else if (is_coarse) state_d = S_COARSE;
        else                state_d = S_FINE_LOAD;
      S_COARSE:
        state_d = S_TLD;
      S_TLD:
        state_d = S_DONE;
      S_FINE_LOAD:
        if (adj_ld_done)  state_d = S_FINE_WAIT_LOW;
        else if (timeout) state_d = S_ERR;
      S_FINE_WAIT_LOW:
        if (!adj_ld_done) state_d = S_FINE_WAIT_HIGH;
        else if (timeout) state_d = S_ERR;
      S_FINE_WAIT_HIGH:
        if (adj_ld_done)
          state_d = (rem_q != 31'd0) ? S_FINE_LOAD
                                     : S_DONE;
        else if (timeout)
          state_d = S_ERR;
      S_DONE:
        state_d = S_IDLE;
      S_ERR:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // State register and per-state dwell counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) cnt_q <= '0;
      else                    cnt_q <= cnt_q + 1'b1;
    end
  end

  // Datapath: latch request, issue strobes, track slew progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q      <= '0;
      rem_q      <= '0;
      period_q   <= '0;
      adj_ld_q   <= 1'b0;
      adj_data_q <= '0;
      tld_q      <= 1'b0;
      tns_q      <= '0;
      tsec_q     <= '0;
    end else begin
      adj_ld_q <= 1'b0;
      tld_q    <= 1'b0;
      if (state_q == S_IDLE && req_valid) begin
        off_q <= req_offset_ns;
        rem_q <= '0;
      end
      if (state_q == S_CLASSIFY &&
          state_d == S_FINE_LOAD)
        rem_q <= 31'(mag);
      if (state_q == S_COARSE) begin
        tns_q  <= ns_d;
        tsec_q <= sec_d;
        tld_q  <= 1'b1;
      end
      if (state_q == S_FINE_LOAD && adj_ld_done) begin
        adj_ld_q   <= 1'b1;
        adj_data_q <= STEP_DELAY;
        period_q   <= adj_val;
        rem_q      <= rem_q - step;
      end
      if (state_d == S_DONE || state_d == S_ERR)
        period_q <= '0;
    end
  end

  assign req_ready        = (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign err              = (state_q == S_ERR);
  assign time_ld          = tld_q;
  assign time_reg_ns_out  = tns_q;
  assign time_reg_sec_out = tsec_q;
  assign adj_ld           = adj_ld_q;
  assign adj_ld_data      = adj_data_q;
  assign period_adj       = period_q;
  assign remaining_ns     = rem_q;

endmodule

// File: tb/tb_rtc_offset_slew_ctrl.sv
// Directed bench for rtc_offset_slew_ctrl with a small RTC
// precise-adjust model; table vectors plus corner sequences.
module tb_rtc_offset_slew_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_offset_ns = '0;
  logic [37:0] time_reg_ns = '0;
  logic [47:0] time_reg_sec = '0;
  logic        time_ld;
  logic [37:0] time_reg_ns_out;
  logic [47:0] time_reg_sec_out;
  logic        adj_ld;
  logic [31:0] adj_ld_data;
  logic [39:0] period_adj;
  logic        adj_ld_done;
  logic        busy;
  logic        done;
  logic        err;
  logic [30:0] remaining_ns;

  rtc_offset_slew_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_offset_ns    (req_offset_ns),
    .time_reg_ns      (time_reg_ns),
    .time_reg_sec     (time_reg_sec),
    .time_ld          (time_ld),
    .time_reg_ns_out  (time_reg_ns_out),
    .time_reg_sec_out (time_reg_sec_out),
    .adj_ld           (adj_ld),
    .adj_ld_data      (adj_ld_data),
    .period_adj       (period_adj),
    .adj_ld_done      (adj_ld_done),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .remaining_ns     (remaining_ns)
  );

  always #5 clk = ~clk;

  // RTC model: done drops 2 cycles after adj_ld, rises 2 later
  logic stuck = 1'b0;
  int   ph;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 0;
      adj_ld_done <= 1'b1;
    end else if (adj_ld && !stuck) begin
      ph <= 1;
    end else if (ph != 0) begin
      ph <= ph + 1;
      if (ph == 2) adj_ld_done <= 1'b0;
      if (ph == 4) begin
        adj_ld_done <= 1'b1;
        ph <= 0;
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] off;
    logic [37:0] tns;
    logic [47:0] tsec;
    logic        e_done;
    logic        e_err;
    int          e_nadj;
    int          e_ntld;
    logic [37:0] e_ns;
    logic [47:0] e_sec;
    logic [39:0] e_per;
  } vec_t;

  vec_t vecs[12];

  int          r_nadj, r_ntld, r_idx, r_adj_idx, r_tld_idx;
  logic        r_done, r_err, r_both, r_busy_bad;
  logic [37:0] r_ns;
  logic [47:0] r_sec;
  logic [39:0] r_per_end;
  logic [30:0] r_rem;
  logic [39:0] r_per[$];
  logic [30:0] r_rems[$];

  // One request; records strobes until done/err or budget
  task automatic run(input logic [31:0] off,
                     input logic [37:0] tns,
                     input logic [47:0] tsec,
                     input int budget);
    r_nadj = 0; r_ntld = 0; r_idx = 0;
    r_adj_idx = -1; r_tld_idx = -1;
    r_done = 0; r_err = 0; r_both = 0;
    r_busy_bad = 0; r_ns = '0; r_sec = '0;
    r_per.delete(); r_rems.delete();
    @(negedge clk);
    time_reg_ns = tns;
    time_reg_sec = tsec;
    req_offset_ns = off;
    req_valid = 1'b1;
    @(negedge clk);
    req_offset_ns = 32'd7;
    for (int i = 1; i <= budget; i++) begin
      r_idx = i;
      if (busy == req_ready) r_busy_bad = 1;
      if (done && err) r_both = 1;
      if (adj_ld) begin
        r_nadj++;
        if (r_adj_idx < 0) r_adj_idx = i;
        r_per.push_back(period_adj);
        r_rems.push_back(remaining_ns);
      end
      if (time_ld) begin
        r_ntld++;
        r_tld_idx = i;
        r_ns = time_reg_ns_out;
        r_sec = time_reg_sec_out;
      end
      if (done || err) begin
        r_done = done;
        r_err = err;
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    r_per_end = period_adj;
    r_rem = remaining_ns;
    if (!r_done && !r_err)
      $display("FAIL run %0h: no done/err in %0d cycles",
               off, budget);
  endtask

  initial begin
    vecs[0]  = '{32'd10, '0, '0, 1, 0, 3, 0, '0, '0,
                 40'h02_0000_0000};
    vecs[1]  = '{-32'sd3, '0, '0, 1, 0, 1, 0, '0, '0,
                 40'hFD_0000_0000};
    vecs[2]  = '{32'd4, '0, '0, 1, 0, 1, 0, '0, '0,
                 40'h04_0000_0000};
    vecs[3]  = '{-32'sd5, '0, '0, 1, 0, 2, 0, '0, '0,
                 40'hFF_0000_0000};
    vecs[4]  = '{32'd2000000, 38'd999999000 << 8, 48'd5,
                 1, 0, 0, 1,
                 (38'd1999000 << 8) + 38'h1000, 48'd6, '0};
    vecs[5]  = '{-32'sd1500000, 38'd1000 << 8, 48'd7,
                 1, 0, 0, 1,
                 (38'd998501000 << 8) + 38'h1000, 48'd6, '0};
    vecs[6]  = '{32'd1000000, '0, '0, 1, 0, 0, 1,
                 (38'd1000000 << 8) + 38'h1000, 48'd0, '0};
    vecs[7]  = '{-32'sd999999999, '0, '0, 1, 0, 0, 1,
                 38'd256 + 38'h1000, 48'hFFFF_FFFF_FFFF, '0};
    vecs[8]  = '{32'd999999999, 38'd999999999 << 8, 48'd10,
                 1, 0, 0, 1,
                 (38'd999999998 << 8) + 38'h1000, 48'd11, '0};
    vecs[9]  = '{32'd0, '0, '0, 1, 0, 0, 0, '0, '0, '0};
    vecs[10] = '{32'h8000_0000, '0, '0, 0, 1, 0, 0,
                 '0, '0, '0};
    vecs[11] = '{32'd1000000000, '0, '0, 0, 1, 0, 0,
                 '0, '0, '0};

    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done_err", {done, err, time_ld, adj_ld}, 0);
    chk("rst_rem", remaining_ns, 0);
    chk("rst_per", period_adj, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      run(vecs[v].off, vecs[v].tns, vecs[v].tsec, 200);
      chk($sformatf("v%0d_done", v), r_done, vecs[v].e_done);
      chk($sformatf("v%0d_err", v), r_err, vecs[v].e_err);
      chk($sformatf("v%0d_nadj", v), r_nadj, vecs[v].e_nadj);
      chk($sformatf("v%0d_ntld", v), r_ntld, vecs[v].e_ntld);
      chk($sformatf("v%0d_rem", v), r_rem, 0);
      chk($sformatf("v%0d_perend", v), r_per_end, 0);
      chk($sformatf("v%0d_busy", v), r_busy_bad, 0);
      chk($sformatf("v%0d_both", v), r_both, 0);
      if (vecs[v].e_ntld > 0) begin
        chk($sformatf("v%0d_ns", v), r_ns, vecs[v].e_ns);
        chk($sformatf("v%0d_sec", v), r_sec, vecs[v].e_sec);
      end
      if (vecs[v].e_nadj > 0)
        chk($sformatf("v%0d_per", v),
            r_per[r_nadj-1], vecs[v].e_per);
    end

    // +10: per-step values and countdown
    run(32'd10, '0, '0, 200);
    chk("p10_n", r_per.size(), 3);
    chk("p10_per0", r_per[0], 40'h04_0000_0000);
    chk("p10_per1", r_per[1], 40'h04_0000_0000);
    chk("p10_per2", r_per[2], 40'h02_0000_0000);
    chk("p10_rem0", r_rems[0], 6);
    chk("p10_rem1", r_rems[1], 2);
    chk("p10_rem2", r_rems[2], 0);
    chk("p10_data", adj_ld_data, 0);

    // latency: zero offset and coarse path
    run(32'd0, '0, '0, 20);
    chk("zero_lat", r_idx, 2);
    run(32'd2000000, 38'd999999000 << 8, 48'd5, 20);
    chk("coarse_tld_lat", r_tld_idx, 3);
    chk("coarse_done_lat", r_idx, 4);

    // RTC never drops adj_ld_done: timeout
    stuck = 1'b1;
    run(32'd5, '0, '0, 1200);
    chk("to_err", r_err, 1);
    chk("to_done", r_done, 0);
    chk("to_nadj", r_nadj, 1);
    chk("to_lat", r_idx - r_adj_idx, 1024);
    chk("to_per", r_per_end, 0);
    chk("to_rem", r_rem, 1);
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    chk("to_idle", {req_ready, busy}, 2'b10);

    // reset during second fine step
    begin
      int n;
      int seen;
      n = 0;
      seen = 0;
      @(negedge clk);
      req_offset_ns = 32'd10;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 100 && n < 2; i++) begin
        if (adj_ld) n++;
        if (n < 2) @(negedge clk);
      end
      chk("mid_adj_seen", n, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_ready", req_ready, 1);
      chk("mid_busy", busy, 0);
      chk("mid_strobes", {adj_ld, time_ld, done, err}, 0);
      chk("mid_per", period_adj, 0);
      chk("mid_rem", remaining_ns, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (adj_ld || busy) seen++;
      end
      chk("mid_quiet", seen, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
